// File: rtl/key_ui_ctrl.sv
// Front-panel key scheduler: turns debounced key pulses/levels into mode, scale and
// freeze settings and offers them to the datapath through a coalescing valid/ready beat.
module key_ui_ctrl #(
    parameter int unsigned HOLD_CNT   = 50000000,
    parameter int unsigned REPEAT_CNT = 10000000,
    parameter int unsigned NUM_MODES  = 4,
    parameter int unsigned SCALE_MAX  = 7,
    parameter int unsigned SCALE_INIT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       mode_edge,
    input  logic       up_edge,
    input  logic       up_lvl,
    input  logic       dn_edge,
    input  logic       dn_lvl,
    input  logic       frz_edge,
    input  logic       cfg_ready,
    output logic       cfg_valid,
    output logic [1:0] cfg_mode,
    output logic [2:0] cfg_scale,
    output logic       cfg_freeze,
    output logic       rpt_active
);

    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
    localparam logic [1:0]       MODE_LAST   = 2'(NUM_MODES - 1);
    localparam logic [2:0]       SCALE_TOP   = 3'(SCALE_MAX);
    localparam logic [2:0]       SCALE_RST   = 3'(SCALE_INIT);

    logic [1:0]       state, state_n;
    logic             dir, dir_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       mode, mode_n;
    logic [2:0]       scale, scale_n;
    logic             freeze, freeze_n;
    logic             dirty, dirty_n;
    logic             cfg_valid_n, cfg_freeze_n;
    logic [1:0]       cfg_mode_n;
    logic [2:0]       cfg_scale_n;
    logic             step_up, step_dn, dir_lvl, change;

    assign dir_lvl = dir ? up_lvl : dn_lvl;

    // Next-state: key actions, scale FSM and the coalescing handshake
    always_comb begin
        state_n      = state;
        dir_n        = dir;
        cnt_n        = cnt;
        mode_n       = mode;
        scale_n      = scale;
        freeze_n     = freeze;
        step_up      = 1'b0;
        step_dn      = 1'b0;
        cfg_valid_n  = cfg_valid;
        cfg_mode_n   = cfg_mode;
        cfg_scale_n  = cfg_scale;
        cfg_freeze_n = cfg_freeze;
        dirty_n      = dirty;

        if (mode_edge) mode_n = (mode == MODE_LAST) ? 2'd0 : mode + 2'd1;
        if (frz_edge)  freeze_n = !freeze;

        case (state)
            S_IDLE: begin
                if (up_edge ^ dn_edge) begin
                    step_up = up_edge;
                    step_dn = dn_edge;
                    dir_n   = up_edge;
                    cnt_n   = '0;
                    state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!dir_lvl) begin
                    state_n = S_IDLE;
                end else if (cnt == HOLD_LAST) begin
                    step_up = dir;
                    step_dn = !dir;
                    cnt_n   = '0;
                    state_n = S_REPEAT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_REPEAT: begin
                if (!dir_lvl) begin
                    state_n = S_IDLE;
                end else if (cnt == REPEAT_LAST) begin
                    step_up = dir;
                    step_dn = !dir;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Saturation is checked before the update so the 3-bit value never wraps
        if (step_up && (scale != SCALE_TOP)) scale_n = scale + 3'd1;
        if (step_dn && (scale != 3'd0))      scale_n = scale - 3'd1;

        change  = mode_edge | frz_edge | (scale_n != scale);
        dirty_n = dirty | change;

        if (!cfg_valid) begin
            if (dirty) begin
                cfg_valid_n  = 1'b1;
                cfg_mode_n   = mode;
                cfg_scale_n  = scale;
                cfg_freeze_n = freeze;
                dirty_n      = change;
            end
        end else if (cfg_ready) begin
            if (dirty || change) begin
                cfg_mode_n   = mode_n;
                cfg_scale_n  = scale_n;
                cfg_freeze_n = freeze_n;
                dirty_n      = 1'b0;
            end else begin
                cfg_valid_n = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            dir        <= 1'b0;
            cnt        <= '0;
            mode       <= 2'd0;
            scale      <= SCALE_RST;
            freeze     <= 1'b0;
            dirty      <= 1'b1;
            cfg_valid  <= 1'b0;
            cfg_mode   <= 2'd0;
            cfg_scale  <= SCALE_RST;
            cfg_freeze <= 1'b0;
            rpt_active <= 1'b0;
        end else begin
            state      <= state_n;
            dir        <= dir_n;
            cnt        <= cnt_n;
            mode       <= mode_n;
            scale      <= scale_n;
            freeze     <= freeze_n;
            dirty      <= dirty_n;
            cfg_valid  <= cfg_valid_n;
            cfg_mode   <= cfg_mode_n;
            cfg_scale  <= cfg_scale_n;
            cfg_freeze <= cfg_freeze_n;
            rpt_active <= (state_n == S_REPEAT);
        end
    end

endmodule

// File: tb/tb_key_ui_ctrl.sv
// Directed bench for key_ui_ctrl with short hold/repeat timing (HOLD_CNT=8, REPEAT_CNT=4).
module tb_key_ui_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       mode_edge = 1'b0;
    logic       up_edge = 1'b0;
    logic       up_lvl = 1'b0;
    logic       dn_edge = 1'b0;
    logic       dn_lvl = 1'b0;
    logic       frz_edge = 1'b0;
    logic       cfg_ready = 1'b1;
    logic       cfg_valid;
    logic [1:0] cfg_mode;
    logic [2:0] cfg_scale;
    logic       cfg_freeze;
    logic       rpt_active;

    int errors = 0;
    int checks = 0;

    key_ui_ctrl #(
        .HOLD_CNT   (8),
        .REPEAT_CNT (4),
        .NUM_MODES  (4),
        .SCALE_MAX  (7),
        .SCALE_INIT (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .mode_edge  (mode_edge),
        .up_edge    (up_edge),
        .up_lvl     (up_lvl),
        .dn_edge    (dn_edge),
        .dn_lvl     (dn_lvl),
        .frz_edge   (frz_edge),
        .cfg_ready  (cfg_ready),
        .cfg_valid  (cfg_valid),
        .cfg_mode   (cfg_mode),
        .cfg_scale  (cfg_scale),
        .cfg_freeze (cfg_freeze),
        .rpt_active (rpt_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles && !cfg_valid; i++) tick();
    endtask

    task automatic check_cfg(input string tag, input logic [1:0] m, input logic [2:0] s, input logic f);
        check({tag, "_valid"}, 32'(cfg_valid), 32'd1);
        check({tag, "_mode"}, 32'(cfg_mode), 32'(m));
        check({tag, "_scale"}, 32'(cfg_scale), 32'(s));
        check({tag, "_freeze"}, 32'(cfg_freeze), 32'(f));
    endtask

    initial begin
        logic seen;

        // Reset values and the first default offer
        resetn = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(cfg_valid), 32'd0);
        check("rst_scale", 32'(cfg_scale), 32'd4);
        check("rst_mode", 32'(cfg_mode), 32'd0);
        check("rst_rpt", 32'(rpt_active), 32'd0);
        resetn = 1'b1;
        wait_valid(3);
        check_cfg("first_offer", 2'd0, 3'd4, 1'b0);
        tick();
        check("first_drop", 32'(cfg_valid), 32'd0);

        // Mode cycling with wrap at four modes
        for (int i = 1; i <= 4; i++) begin
            mode_edge = 1'b1;
            tick();
            mode_edge = 1'b0;
            tick();
            check("mode_valid", 32'(cfg_valid), 32'd1);
            check("mode_val", 32'(cfg_mode), 32'(i % 4));
            tick();
            check("mode_drop", 32'(cfg_valid), 32'd0);
            repeat (7) tick();
        end

        // Back-pressure: changes coalesce while the default offer is stalled
        cfg_ready = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        wait_valid(3);
        mode_edge = 1'b1;
        tick();
        mode_edge = 1'b0;
        frz_edge = 1'b1;
        tick();
        frz_edge = 1'b0;
        dn_edge = 1'b1;
        tick();
        dn_edge = 1'b0;
        tick();
        tick();
        check_cfg("bp_held", 2'd0, 3'd4, 1'b0);
        cfg_ready = 1'b1;
        tick();
        check_cfg("bp_reload", 2'd1, 3'd3, 1'b1);
        tick();
        check("bp_drop", 32'(cfg_valid), 32'd0);

        // Simultaneous up and down edges do nothing
        up_edge = 1'b1;
        dn_edge = 1'b1;
        tick();
        up_edge = 1'b0;
        dn_edge = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen |= cfg_valid;
        end
        check("both_no_offer", 32'(seen), 32'd0);
        check("both_scale", 32'(cfg_scale), 32'd3);

        // Step down to zero, then a saturated step offers nothing
        repeat (3) begin
            dn_edge = 1'b1;
            tick();
            dn_edge = 1'b0;
            repeat (4) tick();
        end
        check("dn_scale0", 32'(cfg_scale), 32'd0);
        dn_edge = 1'b1;
        tick();
        dn_edge = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen |= cfg_valid;
        end
        check("dn_sat_no_offer", 32'(seen), 32'd0);

        // Hold-to-repeat: 4 -> 5 at press, 6 after 8 cycles, 7 after 4 more, then saturate
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        repeat (4) tick();
        up_edge = 1'b1;
        up_lvl = 1'b1;
        tick();
        up_edge = 1'b0;
        tick();
        check_cfg("hold_step1", 2'd0, 3'd5, 1'b0);
        tick();
        check("hold_drop1", 32'(cfg_valid), 32'd0);
        repeat (5) tick();
        check("hold_rpt_lo", 32'(rpt_active), 32'd0);
        tick();
        check("hold_rpt_hi", 32'(rpt_active), 32'd1);
        tick();
        check_cfg("rpt_step6", 2'd0, 3'd6, 1'b0);
        repeat (4) tick();
        check_cfg("rpt_step7", 2'd0, 3'd7, 1'b0);
        seen = 1'b0;
        repeat (7) begin
            tick();
            seen |= cfg_valid;
        end
        check("rpt_sat_quiet", 32'(cfg_valid), 32'd0);
        check("rpt_still_hi", 32'(rpt_active), 32'd1);
        up_lvl = 1'b0;
        tick();
        check("rpt_release", 32'(rpt_active), 32'd0);
        check("rpt_final_scale", 32'(cfg_scale), 32'd7);

        // Reset during REPEAT with a stalled offer
        cfg_ready = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        wait_valid(3);
        up_edge = 1'b1;
        up_lvl = 1'b1;
        tick();
        up_edge = 1'b0;
        repeat (8) tick();
        check("mid_rpt", 32'(rpt_active), 32'd1);
        check("mid_valid", 32'(cfg_valid), 32'd1);
        resetn = 1'b0;
        tick();
        check("abort_valid", 32'(cfg_valid), 32'd0);
        check("abort_rpt", 32'(rpt_active), 32'd0);
        check("abort_scale", 32'(cfg_scale), 32'd4);
        up_lvl = 1'b0;
        cfg_ready = 1'b1;
        resetn = 1'b1;
        wait_valid(3);
        check_cfg("reoffer", 2'd0, 3'd4, 1'b0);
        tick();
        check("reoffer_drop", 32'(cfg_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
